// File: rtl/sound_pkg.sv
// Shared types and constants for the score sequencer and its tone divider.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sound_pkg;

  // Sequencer state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_LATCH = 3'd2;
  localparam logic [2:0] ST_PLAY  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    FETCH = ST_FETCH,
    LATCH = ST_LATCH,
    PLAY  = ST_PLAY,
    DONE  = ST_DONE
  } state_t;

  // A score word with this duration terminates the score
  localparam int END_DUR = 0;

  // Width of the half-period counter; holds the longest production half-period
  localparam int HP_BITS = 17;

  // Key -> clock cycles per half-period of the tone.
  // Production table is C4..B4 at a 50 MHz clock; test_tones gives key+1 for short sims.
  function automatic int half_period(input int key, input bit test_tones);
    int hp;
    if (test_tones) begin
      hp = key + 1;
    end else begin
      case (key)
        1:       hp = 95556;
        2:       hp = 85131;
        3:       hp = 75843;
        4:       hp = 71586;
        5:       hp = 63776;
        6:       hp = 56818;
        7:       hp = 50619;
        default: hp = 47778;
      endcase
    end
    return hp;
  endfunction

endpackage

// File: rtl/score_sequencer_if.sv
// Bundle between game FSM / score RAM (master) and the score sequencer (slave).
// Latency: n/a (wires only); score_data is expected one cycle after score_address.
// Backpressure: none; start is a single-cycle pulse. Loop port exists only with SCORE_LOOP_EN.
interface score_sequencer_if #(
  parameter int CAUSE_BITS = 2,
  parameter int ADDR_BITS  = 7,
  parameter int KEY_BITS   = 3,
  parameter int DUR_BITS   = 4
);
  logic                         start;
  logic [CAUSE_BITS-1:0]        cause;
  logic [ADDR_BITS-1:0]         score_address;
  logic [KEY_BITS+DUR_BITS-1:0] score_data;
  logic                         speaker;
  logic                         busy;
  logic                         done;
  logic [KEY_BITS-1:0]          current_key;
`ifdef SCORE_LOOP_EN
  logic                         loop;

  modport master (
    output start, cause, score_data, loop,
    input  score_address, speaker, busy, done, current_key
  );
  modport slave (
    input  start, cause, score_data, loop,
    output score_address, speaker, busy, done, current_key
  );
`else
  modport master (
    output start, cause, score_data,
    input  score_address, speaker, busy, done, current_key
  );
  modport slave (
    input  start, cause, score_data,
    output score_address, speaker, busy, done, current_key
  );
`endif
endinterface

// File: rtl/tone_divider.sv
// Square-wave generator: toggles speaker every half_period(key) cycles while enabled.
// Latency: first toggle half_period(key) cycles after enable rises; drops to 0 the cycle enable falls.
// Backpressure: none.
module tone_divider
  import sound_pkg::*;
#(
  parameter int KEY_BITS   = 3,
  parameter int NUM_KEYS   = 8,
  parameter bit TEST_TONES = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [KEY_BITS-1:0] key,
  input  logic                enable,
  output logic                speaker
);

  logic [HP_BITS-1:0] hp_cnt;
  logic [HP_BITS-1:0] hp_last;
  logic               tog;
  logic               active;

  // Rest (key 0) and keys beyond the table are silent
  assign active  = enable && (key != '0) && (int'(key) < NUM_KEYS);
  assign hp_last = HP_BITS'(half_period(int'(key), TEST_TONES) - 1);

  // Half-period counter; held at zero while silent so each note starts in phase
  always_ff @(posedge clk) begin
    if (!rst_n || !active) begin
      hp_cnt <= '0;
      tog    <= 1'b0;
    end else if (hp_cnt == hp_last) begin
      hp_cnt <= '0;
      tog    <= ~tog;
    end else begin
      hp_cnt <= hp_cnt + HP_BITS'(1);
    end
  end

  // Gate so the pin goes quiet in the same cycle the note stops
  assign speaker = tog & active;

endmodule

// File: rtl/score_sequencer.sv
// Plays one of NUM_SCORES {key,duration} scores from an external RAM on a tone divider; optional SCORE_LOOP_EN adds Loop.
// Latency: 2 cycles of fetch overhead per note plus dur*TICK_DIV play cycles; Done 1 cycle after the end word.
// Backpressure: none; a new start pre-empts the current score immediately and suppresses Done.
module score_sequencer
  import sound_pkg::*;
#(
  parameter int NUM_SCORES  = 4,
  parameter int CAUSE_BITS  = 2,
  parameter int SCORE_DEPTH = 32,
  parameter int ADDR_BITS   = 7,
  parameter int NUM_KEYS    = 8,
  parameter int KEY_BITS    = 3,
  parameter int DUR_BITS    = 4,
  parameter int TICK_DIV    = 12500000,
  parameter bit TEST_TONES  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  score_sequencer_if.slave  bus
);

  localparam int OFF_BITS  = $clog2(SCORE_DEPTH);
  localparam int TICK_BITS = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_BITS-1:0] TICK_LAST = TICK_BITS'(TICK_DIV - 1);
  localparam logic [OFF_BITS-1:0]  OFF_LAST  = '1;

  state_t                 state;
  logic [ADDR_BITS-1:0]   addr;
  logic [KEY_BITS-1:0]    key_q;
  logic [KEY_BITS-1:0]    cur_key;
  logic [DUR_BITS-1:0]    durcnt;
  logic [TICK_BITS-1:0]   tickcnt;
  logic                   busy_q;
  logic                   done_q;

  logic [KEY_BITS-1:0]    rd_key;
  logic [DUR_BITS-1:0]    rd_dur;
  logic                   key_ok;
  logic                   note_end;
  logic                   last_word;
  logic                   score_end;
  logic                   loop_req;
  logic [ADDR_BITS-1:0]   base_addr;

  assign {rd_key, rd_dur} = bus.score_data;
  assign key_ok    = (rd_key != '0) && (int'(rd_key) < NUM_KEYS);
  assign base_addr = {addr[ADDR_BITS-1:OFF_BITS], {OFF_BITS{1'b0}}};
  assign last_word = (addr[OFF_BITS-1:0] == OFF_LAST);
  assign note_end  = (state == PLAY) && (tickcnt == '0) && (durcnt == DUR_BITS'(1));
  // End of score: terminator word, or the last note of the region finishing (no wrap)
  assign score_end = ((state == LATCH) && (rd_dur == DUR_BITS'(END_DUR))) ||
                     (note_end && last_word);

`ifdef SCORE_LOOP_EN
  assign loop_req = bus.loop;
`else
  assign loop_req = 1'b0;
`endif

  // Sequencer FSM with registered outputs; start outranks every other transition
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr    <= '0;
      key_q   <= '0;
      cur_key <= '0;
      durcnt  <= '0;
      tickcnt <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (bus.start) begin
      state   <= FETCH;
      addr    <= {bus.cause, {OFF_BITS{1'b0}}};
      durcnt  <= '0;
      tickcnt <= '0;
      cur_key <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else if (score_end) begin
      cur_key <= '0;
      durcnt  <= '0;
      tickcnt <= '0;
      done_q  <= 1'b0;
      if (loop_req) begin
        state <= FETCH;
        addr  <= base_addr;
      end else begin
        state  <= DONE;
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
      case (state)
        FETCH: state <= LATCH;
        LATCH: begin
          key_q   <= rd_key;
          durcnt  <= rd_dur;
          tickcnt <= TICK_LAST;
          cur_key <= key_ok ? rd_key : '0;
          state   <= PLAY;
        end
        PLAY: begin
          if (tickcnt == '0) begin
            tickcnt <= TICK_LAST;
            durcnt  <= durcnt - DUR_BITS'(1);
            if (durcnt == DUR_BITS'(1)) begin
              cur_key <= '0;
              addr    <= addr + ADDR_BITS'(1);
              state   <= FETCH;
            end
          end else begin
            tickcnt <= tickcnt - TICK_BITS'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  tone_divider #(
    .KEY_BITS   (KEY_BITS),
    .NUM_KEYS   (NUM_KEYS),
    .TEST_TONES (TEST_TONES)
  ) u_tone (
    .clk     (clk),
    .rst_n   (rst_n),
    .key     (key_q),
    .enable  (state == PLAY),
    .speaker (bus.speaker)
  );

  assign bus.score_address = addr;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.current_key   = cur_key;

endmodule
